// File: rtl/arp_ctrl_if.sv
// Handshake bundle between the ARP control stage and the arp frame engine.
// The master side launches frames; the slave side reports receptions and transmit completion.
interface arp_ctrl_if;
  logic        arp_tx_en;
  logic        arp_tx_type;
  logic [47:0] des_mac;
  logic [31:0] des_ip;
  logic        arp_rx_done;
  logic        arp_rx_type;
  logic [47:0] src_mac;
  logic [31:0] src_ip;
  logic        tx_done;

  modport master (
    output arp_tx_en, arp_tx_type, des_mac, des_ip,
    input  arp_rx_done, arp_rx_type, src_mac, src_ip, tx_done
  );

  modport slave (
    input  arp_tx_en, arp_tx_type, des_mac, des_ip,
    output arp_rx_done, arp_rx_type, src_mac, src_ip, tx_done
  );
endinterface

// File: rtl/arp_ctrl.sv
// ARP control: resolves TARGET_IP with timed retries, answers every received request,
// and keeps a one-entry peer cache for downstream transmit stages.
module arp_ctrl #(
  parameter logic [31:0] TARGET_IP     = 32'hC0A80166,
  parameter int          REPLY_TIMEOUT = 125_000_000,
  parameter int          MAX_RETRY     = 3
) (
  input  logic        gmii_clk,
  input  logic        rst_n,
  input  logic        start_req,
  arp_ctrl_if.master  arp,
  output logic        busy,
  output logic        peer_valid,
  output logic [47:0] peer_mac,
  output logic [31:0] peer_ip,
  output logic        resolve_fail
);

  localparam int             TW         = $clog2(REPLY_TIMEOUT);
  localparam logic [TW-1:0]  TIMER_LAST = TW'(REPLY_TIMEOUT - 1);
  localparam logic [3:0]     RETRY_MAX  = 4'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, TX, TX_WAIT, WAIT_RPL} state_t;

  state_t        state_reg, state_next;
  state_t        ret_reg, ret_next;
  logic          is_reply_reg, is_reply_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [3:0]    attempt_reg, attempt_next;
  logic          rpl_pend_reg, rpl_pend_next;
  logic [47:0]   rpl_mac_reg, rpl_mac_next;
  logic [31:0]   rpl_ip_reg, rpl_ip_next;
  logic          peer_valid_reg, peer_valid_next;
  logic [47:0]   peer_mac_reg, peer_mac_next;
  logic [31:0]   peer_ip_reg, peer_ip_next;
  logic          resolve_fail_reg, resolve_fail_next;
  logic          tx_en_reg, tx_en_next;
  logic          tx_type_reg, tx_type_next;
  logic [47:0]   des_mac_reg, des_mac_next;
  logic [31:0]   des_ip_reg, des_ip_next;

  logic rx_req, rx_peer, rx_learn_reply;

  assign rx_req         = arp.arp_rx_done && !arp.arp_rx_type;
  assign rx_peer        = arp.arp_rx_done && (arp.src_ip == TARGET_IP);
  assign rx_learn_reply = rx_peer && arp.arp_rx_type;

  always_comb begin
    state_next        = state_reg;
    ret_next          = ret_reg;
    is_reply_next     = is_reply_reg;
    timer_next        = timer_reg;
    attempt_next      = attempt_reg;
    rpl_pend_next     = rpl_pend_reg;
    rpl_mac_next      = rpl_mac_reg;
    rpl_ip_next       = rpl_ip_reg;
    peer_valid_next   = peer_valid_reg;
    peer_mac_next     = peer_mac_reg;
    peer_ip_next      = peer_ip_reg;
    resolve_fail_next = resolve_fail_reg;
    tx_en_next        = 1'b0;
    tx_type_next      = tx_type_reg;
    des_mac_next      = des_mac_reg;
    des_ip_next       = des_ip_reg;

    if (rx_req) begin
      rpl_mac_next = arp.src_mac;
      rpl_ip_next  = arp.src_ip;
    end

    case (state_reg)
      IDLE: begin
        if (rpl_pend_reg) begin
          state_next    = TX;
          is_reply_next = 1'b1;
          ret_next      = IDLE;
        end else if (start_req) begin
          resolve_fail_next = 1'b0;
          peer_valid_next   = 1'b0;
          attempt_next      = 4'd1;
          state_next        = TX;
          is_reply_next     = 1'b0;
          ret_next          = WAIT_RPL;
        end
      end
      TX: begin
        state_next = TX_WAIT;
        if (is_reply_reg) rpl_pend_next = 1'b0;
      end
      TX_WAIT: begin
        if (arp.tx_done) begin
          state_next = ret_reg;
          if (!is_reply_reg) timer_next = '0;
        end
      end
      WAIT_RPL: begin
        // Every waiting cycle counts, including the one that detours to send a reply.
        timer_next = timer_reg + TW'(1);
        if (rx_learn_reply) begin
          state_next = IDLE;
        end else if (rpl_pend_reg) begin
          state_next    = TX;
          is_reply_next = 1'b1;
          ret_next      = WAIT_RPL;
        end else if (timer_reg == TIMER_LAST) begin
          if (attempt_reg < RETRY_MAX) begin
            attempt_next  = attempt_reg + 4'd1;
            state_next    = TX;
            is_reply_next = 1'b0;
            ret_next      = WAIT_RPL;
          end else begin
            resolve_fail_next = 1'b1;
            state_next        = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // A request landing in the reply's TX cycle must survive the clear above.
    if (rx_req) rpl_pend_next = 1'b1;

    if (rx_peer) begin
      peer_valid_next = 1'b1;
      peer_mac_next   = arp.src_mac;
      peer_ip_next    = arp.src_ip;
    end

    // Frame fields are captured on entry to TX so they are valid alongside arp_tx_en.
    if (state_next == TX) begin
      tx_en_next   = 1'b1;
      tx_type_next = is_reply_next;
      des_mac_next = is_reply_next ? rpl_mac_next : 48'hFFFF_FFFF_FFFF;
      des_ip_next  = is_reply_next ? rpl_ip_next : TARGET_IP;
    end
  end

  always_ff @(posedge gmii_clk) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      ret_reg          <= IDLE;
      is_reply_reg     <= 1'b0;
      timer_reg        <= '0;
      attempt_reg      <= '0;
      rpl_pend_reg     <= 1'b0;
      rpl_mac_reg      <= '0;
      rpl_ip_reg       <= '0;
      peer_valid_reg   <= 1'b0;
      peer_mac_reg     <= '0;
      peer_ip_reg      <= '0;
      resolve_fail_reg <= 1'b0;
      tx_en_reg        <= 1'b0;
      tx_type_reg      <= 1'b0;
      des_mac_reg      <= 48'hFFFF_FFFF_FFFF;
      des_ip_reg       <= '0;
    end else begin
      state_reg        <= state_next;
      ret_reg          <= ret_next;
      is_reply_reg     <= is_reply_next;
      timer_reg        <= timer_next;
      attempt_reg      <= attempt_next;
      rpl_pend_reg     <= rpl_pend_next;
      rpl_mac_reg      <= rpl_mac_next;
      rpl_ip_reg       <= rpl_ip_next;
      peer_valid_reg   <= peer_valid_next;
      peer_mac_reg     <= peer_mac_next;
      peer_ip_reg      <= peer_ip_next;
      resolve_fail_reg <= resolve_fail_next;
      tx_en_reg        <= tx_en_next;
      tx_type_reg      <= tx_type_next;
      des_mac_reg      <= des_mac_next;
      des_ip_reg       <= des_ip_next;
    end
  end

  assign arp.arp_tx_en   = tx_en_reg;
  assign arp.arp_tx_type = tx_type_reg;
  assign arp.des_mac     = des_mac_reg;
  assign arp.des_ip      = des_ip_reg;
  assign busy            = (state_reg != IDLE) || rpl_pend_reg;
  assign peer_valid      = peer_valid_reg;
  assign peer_mac        = peer_mac_reg;
  assign peer_ip         = peer_ip_reg;
  assign resolve_fail    = resolve_fail_reg;

endmodule
